// File: rtl/adc_avg_capture.sv
// ADC conversion sequencer with 2^ACC_LOG2 sample averaging.
// Completed groups are tagged with a rotation angle and queued in a FWFT FIFO.
module adc_avg_capture #(
  parameter int DATA_W    = 12,
  parameter int ACC_LOG2  = 3,
  parameter int FIFO_LOG2 = 3,
  parameter int TIMEOUT   = 1000
) (
  input  logic                fpga_clk,
  input  logic                rst,
  input  logic                sys_init_ctrl,
  input  logic                adc_en,
  input  logic                trg_tick,
  input  logic [9:0]          rot_count,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [DATA_W-1:0]   adc_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_avg,
  output logic [9:0]          out_angle,
  output logic [FIFO_LOG2:0]  fifo_count,
  output logic                busy,
  output logic                overflow,
  output logic                timeout_err
);

  localparam int ACC_W = DATA_W + ACC_LOG2;
  localparam int ENT_W = DATA_W + 10;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [ACC_LOG2-1:0] CNT_ONE = ACC_LOG2'(1);
  localparam logic [FIFO_LOG2:0] FC_ONE  = (FIFO_LOG2+1)'(1);
  localparam logic [FIFO_LOG2:0] FC_FULL = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE = FIFO_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_PUSH
  } state_t;

  state_t state;
  state_t state_nx;

  logic                 clr;
  logic [ACC_W-1:0]     acc;
  logic [ACC_LOG2-1:0]  sample_cnt;
  logic [9:0]           angle_tag;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 last;
  logic                 tmo_hit;
  logic [DATA_W-1:0]    avg;

  logic [ENT_W-1:0]     mem [DEPTH];
  logic [FIFO_LOG2-1:0] wptr;
  logic [FIFO_LOG2-1:0] rptr;
  logic [ENT_W-1:0]     head;
  logic                 full;
  logic                 pop;
  logic                 push_req;
  logic                 push;

  assign clr     = rst | sys_init_ctrl;
  assign last    = (sample_cnt == '1);
  assign tmo_hit = (tmo_cnt == '0);
  assign avg     = acc[ACC_W-1:ACC_LOG2];

  // State register; any clear abandons an in-flight conversion.
  always_ff @(posedge fpga_clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode plus start pulse and busy flag.
  always_comb begin
    state_nx  = state;
    adc_start = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (adc_en && trg_tick) state_nx = S_START;
      end
      S_START: begin
        adc_start = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        if (adc_done)     state_nx = last ? S_PUSH : S_IDLE;
        else if (tmo_hit) state_nx = S_IDLE;
      end
      S_PUSH:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Accumulator, sample counter, angle tag and conversion timeout.
  always_ff @(posedge fpga_clk) begin
    if (clr) begin
      acc         <= '0;
      sample_cnt  <= '0;
      angle_tag   <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!adc_en && sample_cnt != '0) begin
            acc        <= '0;
            sample_cnt <= '0;
          end
        end
        S_START: begin
          if (sample_cnt == '0) angle_tag <= rot_count;
          tmo_cnt <= TMO_INIT;
        end
        S_WAIT: begin
          if (adc_done) begin
            acc        <= acc + {{ACC_LOG2{1'b0}}, adc_data};
            sample_cnt <= sample_cnt + CNT_ONE;
          end else if (tmo_hit) begin
            acc         <= '0;
            sample_cnt  <= '0;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_ONE;
          end
        end
        S_PUSH: begin
          acc        <= '0;
          sample_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (fifo_count != '0);
  assign full      = (fifo_count == FC_FULL);
  assign pop       = out_valid & out_ready;
  assign push_req  = (state == S_PUSH);
  assign push      = push_req & (~full | pop);
  assign head      = mem[rptr];
  assign out_avg   = out_valid ? head[DATA_W-1:0] : '0;
  assign out_angle = out_valid ? head[ENT_W-1:DATA_W] : '0;

  // Entry storage; stale contents are masked by out_valid.
  always_ff @(posedge fpga_clk) begin
    if (push) mem[wptr] <= {angle_tag, avg};
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge fpga_clk) begin
    if (clr) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FC_ONE;
        2'b01:   fifo_count <= fifo_count - FC_ONE;
        default: fifo_count <= fifo_count;
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_avg_capture.sv
// Scoreboard bench for adc_avg_capture.
// Directed groups; a negedge monitor checks every FIFO handshake.
module tb_adc_avg_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sys_init_ctrl = 1'b0;
  logic        adc_en = 1'b0;
  logic        trg_tick = 1'b0;
  logic [9:0]  rot_count = '0;
  logic        adc_start;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_avg;
  logic [9:0]  out_angle;
  logic [3:0]  fifo_count;
  logic        busy;
  logic        overflow;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int nstart = 0;
  int npops = 0;
  bit tog_en = 1'b0;
  logic [21:0] exp_q[$];
  logic [11:0] gd[8];

  adc_avg_capture dut (
    .fpga_clk      (clk),
    .rst           (rst),
    .sys_init_ctrl (sys_init_ctrl),
    .adc_en        (adc_en),
    .trg_tick      (trg_tick),
    .rot_count     (rot_count),
    .adc_start     (adc_start),
    .adc_done      (adc_done),
    .adc_data      (adc_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_avg       (out_avg),
    .out_angle     (out_angle),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .overflow      (overflow),
    .timeout_err   (timeout_err)
  );

  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Monitor: count start pulses, score every accepted head entry.
  initial begin
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (adc_start === 1'b1) nstart++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        npops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop angle=%0d avg=%0d",
                   out_angle, out_avg);
        end else begin
          e = exp_q.pop_front();
          if ({out_angle, out_avg} !== e) begin
            errors++;
            $display("FAIL pop_data got angle=%0d avg=%0d exp angle=%0d avg=%0d",
                     out_angle, out_avg, e[21:12], e[11:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tog_en) out_ready = ~out_ready;
  endtask

  task automatic sample(input logic [11:0] d, input bit respond);
    int t = 0;
    while (busy && t < 50) begin
      step();
      t++;
    end
    chk("idle_before_tick", busy, 0);
    trg_tick = 1'b1;
    step();
    trg_tick = 1'b0;
    chk("adc_start", adc_start, 1);
    if (respond) begin
      repeat (5) step();
      adc_done = 1'b1;
      adc_data = d;
      step();
      adc_done = 1'b0;
    end
  endtask

  task automatic fill(input int base, input int inc);
    for (int i = 0; i < 8; i++) gd[i] = 12'(base + i * inc);
  endtask

  task automatic group(input logic [9:0] a0, input bit inc,
                       input bit exp_push, input bit pop_at_push);
    int sum = 0;
    rot_count = a0;
    for (int i = 0; i < 8; i++) sum += int'(gd[i]);
    for (int i = 0; i < 8; i++) begin
      sample(gd[i], 1'b1);
      if (inc) rot_count = rot_count + 10'd1;
    end
    if (exp_push) exp_q.push_back({a0, 12'(sum >> 3)});
    if (pop_at_push) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while (fifo_count != 0 && t < 100) begin
      step();
      t++;
    end
    out_ready = 1'b0;
    chk("drain_empty", fifo_count, 0);
  endtask

  initial begin
    int s0;
    int t;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", adc_start, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_avg", out_avg, 0);
    chk("rst_angle", out_angle, 0);

    // basic group
    adc_en = 1'b1;
    s0 = nstart;
    fill(100, 1);
    group(10'd37, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("basic_count", fifo_count, 1);
    chk("basic_avg", out_avg, 103);
    chk("basic_angle", out_angle, 37);
    chk("basic_starts", nstart - s0, 8);
    drain();

    // tag latch and floor
    fill(4095, 0);
    gd[3] = 12'd4094;
    group(10'd200, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk("floor_avg", out_avg, 4094);
    chk("tag_angle", out_angle, 200);
    drain();

    // reset mid-conversion, late done ignored
    sample(12'd0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_busy", busy, 0);
    adc_done = 1'b1;
    adc_data = 12'd4000;
    step();
    adc_done = 1'b0;
    step();
    chk("late_done_busy", busy, 0);
    chk("late_done_count", fifo_count, 0);

    // timeout after three samples
    rot_count = 10'd50;
    sample(12'd10, 1'b1);
    sample(12'd20, 1'b1);
    sample(12'd30, 1'b1);
    sample(12'd0, 1'b0);
    repeat (995) step();
    chk("tmo_early", timeout_err, 0);
    repeat (10) step();
    chk("tmo_set", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    fill(1000, 1);
    group(10'd60, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("post_tmo_avg", out_avg, 1003);
    chk("post_tmo_angle", out_angle, 60);
    drain();

    // overflow: nine groups, no reader
    for (int g = 0; g < 9; g++) begin
      fill((g + 1) * 100, 0);
      group(10'(300 + g), 1'b0, g < 8, 1'b0);
    end
    step();
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    fill(3333, 0);
    group(10'd400, 1'b0, 1'b1, 1'b1);
    step();
    chk("full_pop_count", fifo_count, 8);
    chk("full_pop_ovf", overflow, 1);
    chk("tmo_sticky", timeout_err, 1);
    drain();

    // enable drop discards partial group
    rot_count = 10'd5;
    for (int i = 0; i < 4; i++) sample(12'd50, 1'b1);
    adc_en = 1'b0;
    repeat (3) step();
    adc_en = 1'b1;
    fill(8, 0);
    group(10'd9, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("endrop_avg", out_avg, 8);
    chk("endrop_angle", out_angle, 9);
    fill(500, 2);
    group(10'd11, 1'b0, 1'b1, 1'b0);
    fill(700, 3);
    group(10'd12, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk("pre_init_count", fifo_count, 3);
    chk("pre_init_ovf", overflow, 1);
    sys_init_ctrl = 1'b1;
    exp_q.delete();
    step();
    sys_init_ctrl = 1'b0;
    chk("init_valid", out_valid, 0);
    chk("init_count", fifo_count, 0);
    chk("init_ovf", overflow, 0);
    chk("init_tmo", timeout_err, 0);
    chk("init_avg", out_avg, 0);

    // drain ordering with toggling ready
    s0 = npops;
    out_ready = 1'b0;
    tog_en = 1'b1;
    fill(1, 1);
    group(10'd100, 1'b0, 1'b1, 1'b0);
    fill(2000, 0);
    group(10'd101, 1'b0, 1'b1, 1'b0);
    fill(4000, 1);
    group(10'd102, 1'b0, 1'b1, 1'b0);
    t = 0;
    while ((fifo_count != 0 || exp_q.size() != 0) && t < 100) begin
      step();
      t++;
    end
    tog_en = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    chk("order_pops", npops - s0, 3);
    chk("order_left", exp_q.size(), 0);
    chk("order_count", fifo_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_avg_capture.md
Name: adc_avg_capture

Overview:
- Downstream consumer of the measurement FSM's ADC enable and rotation count.
- On each ADC trigger tick it runs one conversion handshake with the external ADC and accumulates 2^ACC_LOG2 samples.
- Each completed group is tagged with the rotation count latched at the group's first sample and pushed into a small first-word-fall-through (FWFT) FIFO.
- A valid/ready reader (UART/display path) drains the FIFO.
- Runs entirely on fpga_clk.

Parameters:
- DATA_W, 12, ADC sample width.
- ACC_LOG2, 3, log2 of samples per group (8).
- FIFO_LOG2, 3, log2 of FIFO depth (8 entries).
- TIMEOUT, 1000, fpga_clk cycles to wait for adc_done before aborting.

Ports:
- fpga_clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- sys_init_ctrl  in  1  one-cycle system-init pulse; synchronous clear, same effect as rst.
- adc_en  in  1  acquisition enable from the FSM.
- trg_tick  in  1  one-cycle conversion request strobe (1 kHz rate).
- rot_count  in  10  current rotation step count.
- adc_start  out  1  one-cycle conversion start pulse to the ADC.
- adc_done  in  1  one-cycle pulse: adc_data valid this cycle.
- adc_data  in  DATA_W  conversion result.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  reader accepts the head entry.
- out_avg  out  DATA_W  averaged sample at the FIFO head.
- out_angle  out  10  rot_count tag at the FIFO head.
- fifo_count  out  FIFO_LOG2+1  number of stored entries.
- busy  out  1  FSM not in IDLE.
- overflow  out  1  sticky: a group was dropped because the FIFO was full.
- timeout_err  out  1  sticky: a conversion timed out.

Behaviour:
- Reset (rst or sys_init_ctrl; rst has priority, both have identical effect):
  - state=IDLE; acc=0; sample_cnt=0; FIFO emptied.
  - All outputs 0: adc_start, out_valid, out_avg, out_angle, fifo_count, busy, overflow, timeout_err.
  - Reset mid-conversion abandons the conversion; a late adc_done is ignored.
- Accumulator is DATA_W+ACC_LOG2 bits wide and cannot overflow. Average = acc >> ACC_LOG2 (floor, no rounding).
- FSM states:
  - IDLE:
    - If adc_en=0 and sample_cnt!=0: discard the partial group (acc=0, sample_cnt=0).
    - If adc_en=1 and trg_tick=1: go to START.
    - trg_tick is ignored in every other state; no queuing.
  - START:
    - adc_start=1 for exactly this cycle.
    - If sample_cnt==0: latch rot_count into angle_tag.
    - Load timeout counter with TIMEOUT-1; go to WAIT.
  - WAIT:
    - On adc_done: acc += adc_data; sample_cnt++. If sample_cnt was 2^ACC_LOG2-1, go to PUSH; otherwise go to IDLE.
    - adc_done arriving in the same cycle the counter reaches 0 counts as success.
    - If the counter reaches 0 without adc_done: set timeout_err, clear acc and sample_cnt, go to IDLE.
    - adc_en falling during WAIT does not abort the conversion; the partial group is discarded on return to IDLE.
    - adc_done outside WAIT is ignored.
  - PUSH (one cycle):
    - Write {angle_tag, avg} if the FIFO is not full, or if it is full and a pop occurs in the same cycle (count unchanged).
    - Otherwise drop the group and set overflow.
    - Clear acc and sample_cnt; go to IDLE.
- Latency: last adc_done → entry visible (out_valid/out_avg) 2 cycles later (WAIT→PUSH, then registered write).
- FIFO:
  - FWFT: out_avg/out_angle show the head entry whenever out_valid=1.
  - Pop when out_valid & out_ready.
  - Pop on an empty FIFO has no effect.
  - Pointers wrap modulo 2^FIFO_LOG2.
  - fifo_count is registered and updates the cycle after a push or pop.
- rot_count changing mid-group has no effect; the tag is the value latched at the first sample.
- busy=1 in START, WAIT and PUSH.
- Sticky flags clear only on reset.

Test Plan:
- Basic group: adc_en=1, rot_count=37, 8 ticks, each answered 5 cycles after adc_start with adc_data 100,101,…,107 → exactly one entry: out_avg=103 (828>>3), out_angle=37, fifo_count=1; 8 adc_start pulses seen.
- Tag latch and floor: rot_count incremented after every sample, data all 4095 except one 4094 → out_avg=4094 (32759>>3), out_angle = value at first sample.
- Timeout: no adc_done after the 3rd sample → timeout_err=1 at cycle TIMEOUT after START; the next 8 good samples form a clean group (no residue of the aborted samples).
- Overflow: out_ready=0, 9 complete groups → fifo_count=8, overflow=1, the 9th group is absent. Then pop at full during PUSH of a 10th group → accepted, count stays 8, overflow unchanged.
- Enable drop / reset: adc_en=0 after 4 samples → no entry and sample_cnt cleared. sys_init_ctrl pulse with 3 entries stored → out_valid=0, fifo_count=0, flags 0 the next cycle.
- Drain ordering: 3 groups with distinct data, out_ready=1 toggled every other cycle → entries pop in FIFO order, one per accepted handshake, no duplicates.
